// File: rtl/snn_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// snn_cfg_sequencer
//
// Drives a small configuration table out to an SNN core over AXI-Lite, then
// keeps polling the core's spike-count register.
//
// Sequence:
//    start -> wait STARTUP_CYCLES -> write every table entry (one at a time)
//    -> cfg_done -> read POLL_ADDR every POLL_PERIOD cycles until stop.
// Any bad response or a handshake that exceeds TIMEOUT cycles parks the
// block in ERR until the next start.
//
// Ports:
//    aclk, aresetn          clock, asynchronous active-low reset
//    start, stop            single-cycle control pulses
//    cfg_idx                table index presented to the table
//    cfg_addr/data/last     table entry for cfg_idx (combinational)
//    m_axi_*                AXI-Lite master, 32-bit address/data
//    busy                   1 outside IDLE/RUN/ERR
//    cfg_done               table fully written
//    err, err_code          01 = bad bresp, 10 = bad rresp, 11 = timeout
//    poll_data, poll_valid  last polled value, 1-cycle strobe on update
// -----------------------------------------------------------------------------
module snn_cfg_sequencer #(
   parameter int unsigned STARTUP_CYCLES = 1048576,
   parameter int unsigned POLL_PERIOD    = 16777216,
   parameter logic [31:0] POLL_ADDR      = 32'h14,
   parameter int unsigned TIMEOUT        = 1024
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        start,
   input  logic        stop,
   output logic [3:0]  cfg_idx,
   input  logic [31:0] cfg_addr,
   input  logic [31:0] cfg_data,
   input  logic        cfg_last,
   output logic [31:0] m_axi_awaddr,
   output logic [2:0]  m_axi_awprot,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   input  logic [1:0]  m_axi_bresp,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready,
   output logic [31:0] m_axi_araddr,
   output logic [2:0]  m_axi_arprot,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready,
   output logic        busy,
   output logic        cfg_done,
   output logic        err,
   output logic [1:0]  err_code,
   output logic [31:0] poll_data,
   output logic        poll_valid
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_WR, S_WRESP, S_RUN, S_RD, S_RDATA, S_ERR
   } state_t;

   // Terminal counts; all counters run 0..N-1.
   localparam logic [31:0] WAIT_LAST = 32'(STARTUP_CYCLES - 1);
   localparam logic [31:0] POLL_LAST = 32'(POLL_PERIOD - 1);
   localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 1);

   state_t      state_reg, state_next;
   logic [31:0] wait_cnt_reg, wait_cnt_next;
   logic [31:0] poll_cnt_reg, poll_cnt_next;
   logic [31:0] to_cnt_reg, to_cnt_next;
   logic [3:0]  cfg_idx_reg, cfg_idx_next;
   logic [31:0] addr_lat_reg, addr_lat_next;
   logic [31:0] data_lat_reg, data_lat_next;
   logic        last_lat_reg, last_lat_next;
   logic        load_pend_reg, load_pend_next;
   logic        stop_pend_reg, stop_pend_next;
   logic        awvalid_reg, awvalid_next;
   logic        wvalid_reg, wvalid_next;
   logic        bready_reg, bready_next;
   logic        arvalid_reg, arvalid_next;
   logic        rready_reg, rready_next;
   logic [31:0] araddr_reg, araddr_next;
   logic        cfg_done_reg, cfg_done_next;
   logic [1:0]  err_code_reg, err_code_next;
   logic [31:0] poll_data_reg, poll_data_next;
   logic        poll_valid_reg, poll_valid_next;

   // A write channel is still pending if its valid is up and not accepted now.
   logic aw_left, w_left;
   assign aw_left = awvalid_reg & ~m_axi_awready;
   assign w_left  = wvalid_reg  & ~m_axi_wready;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_reg      <= S_IDLE;
         wait_cnt_reg   <= '0;
         poll_cnt_reg   <= '0;
         to_cnt_reg     <= '0;
         cfg_idx_reg    <= '0;
         addr_lat_reg   <= '0;
         data_lat_reg   <= '0;
         last_lat_reg   <= 1'b0;
         load_pend_reg  <= 1'b0;
         stop_pend_reg  <= 1'b0;
         awvalid_reg    <= 1'b0;
         wvalid_reg     <= 1'b0;
         bready_reg     <= 1'b0;
         arvalid_reg    <= 1'b0;
         rready_reg     <= 1'b0;
         araddr_reg     <= '0;
         cfg_done_reg   <= 1'b0;
         err_code_reg   <= 2'b00;
         poll_data_reg  <= '0;
         poll_valid_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         wait_cnt_reg   <= wait_cnt_next;
         poll_cnt_reg   <= poll_cnt_next;
         to_cnt_reg     <= to_cnt_next;
         cfg_idx_reg    <= cfg_idx_next;
         addr_lat_reg   <= addr_lat_next;
         data_lat_reg   <= data_lat_next;
         last_lat_reg   <= last_lat_next;
         load_pend_reg  <= load_pend_next;
         stop_pend_reg  <= stop_pend_next;
         awvalid_reg    <= awvalid_next;
         wvalid_reg     <= wvalid_next;
         bready_reg     <= bready_next;
         arvalid_reg    <= arvalid_next;
         rready_reg     <= rready_next;
         araddr_reg     <= araddr_next;
         cfg_done_reg   <= cfg_done_next;
         err_code_reg   <= err_code_next;
         poll_data_reg  <= poll_data_next;
         poll_valid_reg <= poll_valid_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      wait_cnt_next   = wait_cnt_reg;
      poll_cnt_next   = poll_cnt_reg;
      to_cnt_next     = to_cnt_reg;
      cfg_idx_next    = cfg_idx_reg;
      addr_lat_next   = addr_lat_reg;
      data_lat_next   = data_lat_reg;
      last_lat_next   = last_lat_reg;
      load_pend_next  = load_pend_reg;
      stop_pend_next  = stop_pend_reg;
      awvalid_next    = awvalid_reg;
      wvalid_next     = wvalid_reg;
      bready_next     = bready_reg;
      arvalid_next    = arvalid_reg;
      rready_next     = rready_reg;
      araddr_next     = araddr_reg;
      cfg_done_next   = cfg_done_reg;
      err_code_next   = err_code_reg;
      poll_data_next  = poll_data_reg;
      poll_valid_next = 1'b0;

      case (state_reg)
         S_IDLE, S_ERR: begin
            if (start) begin
               state_next    = S_WAIT;
               cfg_idx_next  = 4'd0;
               cfg_done_next = 1'b0;
               wait_cnt_next = '0;
               err_code_next = 2'b00;
            end
         end

         S_WAIT: begin
            if (wait_cnt_reg == WAIT_LAST) begin
               addr_lat_next  = cfg_addr;
               data_lat_next  = cfg_data;
               last_lat_next  = cfg_last;
               awvalid_next   = 1'b1;
               wvalid_next    = 1'b1;
               to_cnt_next    = '0;
               load_pend_next = 1'b0;
               state_next     = S_WR;
            end else begin
               wait_cnt_next = wait_cnt_reg + 32'd1;
            end
         end

         S_WR: begin
            if (load_pend_reg) begin
               // cfg_idx moved last cycle; the table output is now valid.
               addr_lat_next  = cfg_addr;
               data_lat_next  = cfg_data;
               last_lat_next  = cfg_last;
               awvalid_next   = 1'b1;
               wvalid_next    = 1'b1;
               to_cnt_next    = '0;
               load_pend_next = 1'b0;
            end else begin
               awvalid_next = aw_left;
               wvalid_next  = w_left;
               if (!aw_left && !w_left) begin
                  bready_next = 1'b1;
                  to_cnt_next = '0;
                  state_next  = S_WRESP;
               end else if (to_cnt_reg == TO_LAST) begin
                  awvalid_next  = 1'b0;
                  wvalid_next   = 1'b0;
                  err_code_next = 2'b11;
                  state_next    = S_ERR;
               end else begin
                  to_cnt_next = to_cnt_reg + 32'd1;
               end
            end
         end

         S_WRESP: begin
            if (m_axi_bvalid) begin
               bready_next = 1'b0;
               if (m_axi_bresp != 2'b00) begin
                  err_code_next = 2'b01;
                  state_next    = S_ERR;
               end else if (last_lat_reg) begin
                  cfg_done_next = 1'b1;
                  poll_cnt_next = '0;
                  state_next    = S_RUN;
               end else begin
                  // 4-bit index wraps 15 -> 0 on its own.
                  cfg_idx_next   = cfg_idx_reg + 4'd1;
                  load_pend_next = 1'b1;
                  state_next     = S_WR;
               end
            end else if (to_cnt_reg == TO_LAST) begin
               bready_next   = 1'b0;
               err_code_next = 2'b11;
               state_next    = S_ERR;
            end else begin
               to_cnt_next = to_cnt_reg + 32'd1;
            end
         end

         S_RUN: begin
            if (stop) begin
               state_next = S_IDLE;
            end else if (poll_cnt_reg == POLL_LAST) begin
               poll_cnt_next  = '0;
               araddr_next    = POLL_ADDR;
               arvalid_next   = 1'b1;
               to_cnt_next    = '0;
               stop_pend_next = 1'b0;
               state_next     = S_RD;
            end else begin
               poll_cnt_next = poll_cnt_reg + 32'd1;
            end
         end

         S_RD: begin
            // A stop here is remembered and honoured once the read completes.
            stop_pend_next = stop_pend_reg | stop;
            if (m_axi_arready) begin
               arvalid_next = 1'b0;
               rready_next  = 1'b1;
               to_cnt_next  = '0;
               state_next   = S_RDATA;
            end else if (to_cnt_reg == TO_LAST) begin
               arvalid_next   = 1'b0;
               err_code_next  = 2'b11;
               stop_pend_next = 1'b0;
               state_next     = S_ERR;
            end else begin
               to_cnt_next = to_cnt_reg + 32'd1;
            end
         end

         S_RDATA: begin
            stop_pend_next = stop_pend_reg | stop;
            if (m_axi_rvalid) begin
               rready_next    = 1'b0;
               stop_pend_next = 1'b0;
               if (m_axi_rresp != 2'b00) begin
                  err_code_next = 2'b10;
                  state_next    = S_ERR;
               end else begin
                  poll_data_next  = m_axi_rdata;
                  poll_valid_next = 1'b1;
                  state_next      = (stop_pend_reg || stop) ? S_IDLE : S_RUN;
               end
            end else if (to_cnt_reg == TO_LAST) begin
               rready_next    = 1'b0;
               err_code_next  = 2'b11;
               stop_pend_next = 1'b0;
               state_next     = S_ERR;
            end else begin
               to_cnt_next = to_cnt_reg + 32'd1;
            end
         end

         default: state_next = S_IDLE;
      endcase
   end

   assign cfg_idx       = cfg_idx_reg;
   assign m_axi_awaddr  = addr_lat_reg;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = awvalid_reg;
   assign m_axi_wdata   = data_lat_reg;
   assign m_axi_wstrb   = 4'hF;
   assign m_axi_wvalid  = wvalid_reg;
   assign m_axi_bready  = bready_reg;
   assign m_axi_araddr  = araddr_reg;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = arvalid_reg;
   assign m_axi_rready  = rready_reg;
   assign busy          = (state_reg != S_IDLE) && (state_reg != S_RUN) && (state_reg != S_ERR);
   assign cfg_done      = cfg_done_reg;
   assign err           = (state_reg == S_ERR);
   assign err_code      = err_code_reg;
   assign poll_data     = poll_data_reg;
   assign poll_valid    = poll_valid_reg;

endmodule

// File: doc/snn_cfg_sequencer.md
SNN_CFG_SEQUENCER -- requirements
Module: snn_cfg_sequencer

Interface
REQ-001 SHALL have parameter STARTUP_CYCLES, default 1048576: idle cycles after start before the first config write.
REQ-002 SHALL have parameter POLL_PERIOD, default 16777216: cycles between status reads in RUN.
REQ-003 SHALL have parameter POLL_ADDR, default 32'h14: spike-count register address polled in RUN.
REQ-004 SHALL have parameter TIMEOUT, default 1024: maximum cycles allowed for any single AXI channel handshake.
REQ-005 SHALL have ports aclk in 1 (only clock), then aresetn in 1; reset is asynchronous and active-low.
REQ-006 SHALL have ports start in 1 (pulse that begins the sequence) and stop in 1 (pulse that returns the block to IDLE from RUN).
REQ-007 SHALL have ports cfg_idx out 4 (table index) and cfg_addr in 32 / cfg_data in 32 / cfg_last in 1, supplied combinationally for cfg_idx.
REQ-008 SHALL have AXI-Lite master ports m_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready, all at standard widths (32-bit addr/data).
REQ-009 SHALL have outputs busy 1, cfg_done 1, err 1, err_code 2, poll_data 32, poll_valid 1.

Function
REQ-010 SHALL implement states IDLE, WAIT, WR, WRESP, RUN, RD, RDATA, ERR.
REQ-011 IDLE: start -> WAIT, cfg_idx=0, cfg_done=0, counter cleared; start is ignored in every other state except ERR.
REQ-012 WAIT: count STARTUP_CYCLES cycles, then latch cfg_addr/cfg_data/cfg_last into registers and go to WR.
REQ-013 WR: assert awvalid and wvalid together on the same cycle; drop each independently on its own ready; when both have completed (same or different cycles) go to WRESP with bready=1.
REQ-014 awaddr/wdata SHALL be driven from the latched registers, stable while valid; wstrb=4'hF; awprot=arprot=3'b000.
REQ-015 WRESP: on bvalid, drop bready; if bresp!=0 -> ERR with err_code=2'b01; else if latched last=1 -> RUN with cfg_done=1; else cfg_idx+1, latch the next entry the following cycle, go to WR.
REQ-016 RUN: free-running poll counter; on reaching POLL_PERIOD-1, clear it and go to RD with araddr=POLL_ADDR.
REQ-017 RD: assert arvalid until arready; then go to RDATA with rready=1.
REQ-018 RDATA: on rvalid, drop rready; if rresp!=0 -> ERR with err_code=2'b10; else capture poll_data=rdata, pulse poll_valid for exactly 1 cycle, go to RUN.
REQ-019 Timeout: a per-handshake counter is cleared on entry to WR/WRESP/RD/RDATA; if it reaches TIMEOUT before completion, drop all valid/ready outputs and go to ERR with err_code=2'b11.
REQ-020 ERR: err=1 and all AXI valid/ready outputs=0; start clears err/err_code and goes to WAIT, as from IDLE.
REQ-021 stop: in RUN -> IDLE immediately; during RD/RDATA it SHALL take effect only after the transaction completes (no AXI valid withdrawn before its handshake).
REQ-022 busy SHALL be 1 in every state except IDLE, RUN and ERR.
REQ-023 cfg_idx SHALL wrap 15->0 without error when the table has no cfg_last; the sequence continues.
REQ-024 At most one AXI transaction SHALL be outstanding at any time.

Reset
REQ-025 aresetn low SHALL force IDLE asynchronously, even mid-transaction, and clear every output to 0: all valids/readies, addresses, data, cfg_idx, busy, cfg_done, err, err_code, poll_data, poll_valid.
REQ-026 Counters and latched table registers SHALL reset to 0; after release, nothing happens until start.

Verification (STARTUP_CYCLES=4, POLL_PERIOD=16, TIMEOUT=8)
REQ-027 Table {0x0C:1000, 0x00:1(last)}, zero-wait slave, start -> writes in order, cfg_done=1, first read of 0x14 16 cycles later, poll_valid pulses once with the slave rdata 0x2A.
REQ-028 awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held stable 3 cycles, single bready handshake, then next entry.
REQ-029 bresp=2'b10 on the second write -> ERR, err_code=01, no further AXI activity; start -> restarts from cfg_idx=0.
REQ-030 arready never asserted -> after 8 cycles arvalid=0, err=1, err_code=11.
REQ-031 aresetn low while in WRESP with bready=1 -> all outputs 0 in the same cycle; after release, block stays IDLE without start.
REQ-032 stop asserted while in RDATA -> poll_valid pulses on rvalid, then IDLE, busy=0.
